// File: rtl/board_input_ctrl.sv
// Front-panel input controller: synchronises and debounces run/step buttons and the LED switch, runs HALT/RUN/STEP.
// Latency: raw edge to accepted level 2+DEBOUNCE_CYCLES cycles; one more cycle to the registered FSM state.
// Backpressure: none; all inputs are level-sampled every cycle and outputs are plain levels/strobes.
module board_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_step,
  input  logic sw_leds,
  input  logic halt_req,
  output logic cpu_state,
  output logic cpu_en,
  output logic step_pulse,
  output logic leds_switch
);

  // Bit 0 = run button, bit 1 = step button, bit 2 = LED switch.
  localparam int          NIN      = 3;
  localparam logic [31:0] CNT_LAST = 32'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] acc;
  logic [1:0]     acc_prev;   // only the buttons need edge detection
  logic [31:0]    cnt [NIN];

  logic   press_run;
  logic   press_step;
  state_t state;
  state_t state_nxt;

  // Two-flop synchronisers, per-input debounce counters and accepted levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      acc      <= '0;
      acc_prev <= '0;
      for (int i = 0; i < NIN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= {sw_leds, btn_step, btn_run};
      sync2    <= sync1;
      acc_prev <= acc[1:0];
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == acc[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          acc[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 32'd1;
        end
      end
    end
  end

  // Presses are rising edges of the accepted level; releases are ignored.
  assign press_run   = acc[0] & ~acc_prev[0];
  assign press_step  = acc[1] & ~acc_prev[1];
  assign leds_switch = acc[2];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HALT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; halt_req has top priority except in STEP, which always completes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      HALT: begin
        if (halt_req)        state_nxt = HALT;
        else if (press_run)  state_nxt = RUN;
        else if (press_step) state_nxt = STEP;
      end
      RUN: begin
        if (halt_req)       state_nxt = HALT;
        else if (press_run) state_nxt = HALT;
      end
      STEP:    state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    cpu_state  = (state == RUN);
    cpu_en     = (state == RUN) || (state == STEP);
    step_pulse = (state == STEP);
  end

endmodule

// File: tb/tb_board_input_ctrl.sv
// Directed bench for board_input_ctrl with a short debounce interval.
// Expected outputs are queued against future cycle numbers when stimulus is applied.
// Each clock the due entries are popped and compared against {cpu_state, cpu_en, step_pulse, leds_switch}.
module tb_board_input_ctrl;

  localparam int D   = 4;
  localparam int LAT = D + 3;   // raw edge to FSM state change
  localparam int LLT = D + 2;   // raw edge to leds_switch change

  localparam logic [3:0] Z  = 4'b0000;
  localparam logic [3:0] RN = 4'b1100;
  localparam logic [3:0] ST = 4'b0110;
  localparam logic [3:0] LD = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst, btn_run, btn_step, sw_leds, halt_req;
  logic cpu_state, cpu_en, step_pulse, leds_switch;

  exp_t q[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  board_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_run    (btn_run),
    .btn_step   (btn_step),
    .sw_leds    (sw_leds),
    .halt_req   (halt_req),
    .cpu_state  (cpu_state),
    .cpu_en     (cpu_en),
    .step_pulse (step_pulse),
    .leds_switch(leds_switch)
  );

  task automatic exp_rng(input int lo, input int hi, input logic [3:0] v);
    for (int i = lo; i <= hi; i++) q.push_back('{cyc + i, v});
  endtask

  task automatic tick(input string tag);
    logic [3:0] obs;
    exp_t       e;
    @(posedge clk);
    #1;
    cyc++;
    obs = {cpu_state, cpu_en, step_pulse, leds_switch};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      tests++;
      assert (e.cyc == cyc && obs === e.val) else begin
        fails++;
        $error("FAIL %s cyc=%0d due=%0d observed=%b expected=%b", tag, cyc, e.cyc, obs, e.val);
      end
    end
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; sw_leds = 1'b0; halt_req = 1'b0;

    // Reset state.
    exp_rng(1, 1, Z);
    tick("reset");
    rst = 1'b0;

    // 1: hold run, release, re-press to stop.
    btn_run = 1'b1;
    exp_rng(1, LAT - 1, Z);
    exp_rng(LAT, 12, RN);
    ticks(12, "run_press");
    btn_run = 1'b0;
    exp_rng(1, 8, RN);
    ticks(8, "run_release");
    btn_run = 1'b1;
    exp_rng(1, LAT - 1, RN);
    exp_rng(LAT, 9, Z);
    ticks(9, "run_stop");
    btn_run = 1'b0;
    exp_rng(1, 8, Z);
    ticks(8, "stop_release");

    // 2: single step, held for 20 cycles.
    btn_step = 1'b1;
    exp_rng(1, LAT - 1, Z);
    exp_rng(LAT, LAT, ST);
    exp_rng(LAT + 1, 20, Z);
    ticks(20, "step");
    btn_step = 1'b0;
    exp_rng(1, 8, Z);
    ticks(8, "step_release");

    // 3: 3-cycle glitch rejected, 4-cycle pulse accepted.
    btn_run = 1'b1;
    exp_rng(1, 10, Z);
    ticks(3, "glitch");
    btn_run = 1'b0;
    ticks(7, "glitch");
    tests++;
    assert (dut.cnt[0] === 32'd0) else begin
      fails++;
      $error("FAIL glitch_cnt observed=%0d expected=0", dut.cnt[0]);
    end
    btn_run = 1'b1;
    exp_rng(1, LAT - 1, Z);
    exp_rng(LAT, 12, RN);
    ticks(4, "pulse4");
    btn_run = 1'b0;
    ticks(8, "pulse4");
    halt_req = 1'b1;
    exp_rng(1, 1, Z);
    tick("halt_after_pulse");
    halt_req = 1'b0;

    // 4: simultaneous run+step -> RUN without a step; then halt_req blocks presses.
    btn_run = 1'b1; btn_step = 1'b1;
    exp_rng(1, LAT - 1, Z);
    exp_rng(LAT, 10, RN);
    ticks(10, "run_and_step");
    btn_run = 1'b0; btn_step = 1'b0;
    exp_rng(1, 8, RN);
    ticks(8, "run_and_step_rel");
    halt_req = 1'b1; btn_run = 1'b1;
    exp_rng(1, 20, Z);
    ticks(12, "halt_req_press");
    btn_run = 1'b0;
    ticks(8, "halt_req_release");
    halt_req = 1'b0;
    exp_rng(1, 3, Z);
    ticks(3, "halt_req_drop");

    // 5: LED switch follows with filtering of short bounces.
    sw_leds = 1'b1;
    exp_rng(1, LLT - 1, Z);
    exp_rng(LLT, 10, LD);
    ticks(10, "leds_up");
    sw_leds = 1'b0;
    exp_rng(1, LLT - 1, LD);
    exp_rng(LLT, 10, Z);
    ticks(10, "leds_down");
    sw_leds = 1'b1;
    exp_rng(1, 4 + LLT - 1, Z);
    exp_rng(4 + LLT, 14, LD);
    ticks(2, "leds_bounce_up");
    sw_leds = 1'b0;
    ticks(2, "leds_bounce_up");
    sw_leds = 1'b1;
    ticks(10, "leds_bounce_up");
    sw_leds = 1'b0;
    exp_rng(1, 4 + LLT - 1, LD);
    exp_rng(4 + LLT, 14, Z);
    ticks(2, "leds_bounce_dn");
    sw_leds = 1'b1;
    ticks(2, "leds_bounce_dn");
    sw_leds = 1'b0;
    ticks(10, "leds_bounce_dn");

    // 6: reset mid-RUN and mid-count; fresh debounce afterwards.
    btn_run = 1'b1;
    exp_rng(1, LAT - 1, Z);
    exp_rng(LAT, 9, RN);
    ticks(9, "pre_rst_run");
    btn_step = 1'b1;
    exp_rng(1, 3, RN);
    ticks(3, "pre_rst_count");
    rst = 1'b1;
    exp_rng(1, 1, Z);
    tick("mid_rst");
    rst = 1'b0;
    tests++;
    assert (dut.cnt[1] === 32'd0) else begin
      fails++;
      $error("FAIL rst_cnt observed=%0d expected=0", dut.cnt[1]);
    end
    exp_rng(1, LAT - 1, Z);
    exp_rng(LAT, 10, RN);
    ticks(10, "post_rst_run");
    btn_run = 1'b0; btn_step = 1'b0;

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      fails++;
      $error("FAIL unchecked due=%0d observed=none expected=%b", e.cyc, e.val);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
